screen_fifo_param: RTL and testbench

//  Parametrised valid/ready FIFO buffering UART-formatted words between producers (keypad/note logic)
//  and the screen transmitter. Successor to the fixed 8x10 screen buffer: all DEPTH entries usable,

---
 rtl/screen_fifo_param_pkg.sv | 14 +
 rtl/screen_fifo_param_if.sv | 34 +++
 rtl/screen_fifo_param_ram.sv | 27 ++
 rtl/screen_fifo_param.sv | 115 +++++++++++
 tb/tb_screen_fifo_param.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/screen_fifo_param_pkg.sv
// Shared types and constants for the screen word path (producer, FIFO, screen TX).
package screen_fifo_param_pkg;

  // UART frame: start bit + 8 data bits + stop bit
  localparam int UART_W = 10;

  typedef logic [UART_W-1:0] screen_word_t;

  // Occupancy counter width: must hold 0..depth inclusive
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/screen_fifo_param_if.sv
// Valid/ready bus between the word producers/consumer and the screen FIFO.
interface screen_fifo_param_if
  import screen_fifo_param_pkg::*;
#(
  parameter int DW    = UART_W,
  parameter int DEPTH = 8
);
  localparam int CW = count_w(DEPTH);

  logic          flush;
  logic          err_clr;
  logic          ivalid;
  logic          iready;
  logic [DW-1:0] idata;
  logic          ovalid;
  logic          oready;
  logic [DW-1:0] odata;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;

  // Environment side: producer, screen consumer and control
  modport master (
    output flush, err_clr, ivalid, idata, oready,
    input  iready, ovalid, odata, count, almost_full, almost_empty, overflow
  );

  // FIFO side
  modport slave (
    input  flush, err_clr, ivalid, idata, oready,
    output iready, ovalid, odata, count, almost_full, almost_empty, overflow
  );
endinterface

// File: rtl/screen_fifo_param_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read so the head
// word can be prefetched into the output register in the same cycle.
module screen_fifo_param_ram
  import screen_fifo_param_pkg::*;
#(
  parameter int DW    = UART_W,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem_r [DEPTH];

  // Write port: storage carries no reset, validity is tracked by the count
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];
endmodule

// File: rtl/screen_fifo_param.sv
// First-word-fall-through valid/ready FIFO for UART-formatted screen words.
// Full/empty are decided by the occupancy count; all outputs are registered.
module screen_fifo_param
  import screen_fifo_param_pkg::*;
#(
  parameter int DW       = UART_W,
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6,
  parameter int AE_LEVEL = 1
) (
  input  logic               clk,
  input  logic               reset,
  screen_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          iready_r, ovalid_r, af_r, ae_r, ovf_r;
  logic [DW-1:0] odata_r;

  logic          push_s, pop_s, ovf_nx_s;
  logic [CW-1:0] remain_s, count_nx_s;
  logic [AW-1:0] wr_ptr_nx_s, rd_ptr_nx_s;
  logic [DW-1:0] odata_nx_s, ram_rdata_s;

  screen_fifo_param_ram #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (push_s),
    .waddr (wr_ptr_r),
    .wdata (bus.idata),
    .raddr (rd_ptr_nx_s),
    .rdata (ram_rdata_s)
  );

  // Handshakes, next pointers and next occupancy; flush discards both sides
  always_comb begin
    push_s   = bus.ivalid && iready_r && !bus.flush;
    pop_s    = ovalid_r && bus.oready && !bus.flush;
    remain_s = count_r - CW'(pop_s);
    if (bus.flush) begin
      count_nx_s  = '0;
      wr_ptr_nx_s = '0;
      rd_ptr_nx_s = '0;
    end else begin
      count_nx_s  = remain_s + CW'(push_s);
      wr_ptr_nx_s = wr_ptr_r + AW'(push_s);
      rd_ptr_nx_s = rd_ptr_r + AW'(pop_s);
    end
  end

  // Next head word: bypass the incoming word when it becomes the only entry
  always_comb begin
    odata_nx_s = odata_r;
    if (bus.flush) begin
      odata_nx_s = '0;
    end else if (remain_s == '0) begin
      if (push_s) begin
        odata_nx_s = bus.idata;
      end else begin
        odata_nx_s = odata_r;
      end
    end else begin
      odata_nx_s = ram_rdata_s;
    end
  end

  // Sticky overflow: a rejected push sets it, and setting wins over clearing
  always_comb begin
    if (bus.ivalid && !iready_r) begin
      ovf_nx_s = 1'b1;
    end else if (bus.err_clr) begin
      ovf_nx_s = 1'b0;
    end else begin
      ovf_nx_s = ovf_r;
    end
  end

  // State and registered outputs; flags follow the next occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      iready_r <= 1'b0;
      ovalid_r <= 1'b0;
      odata_r  <= '0;
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
      ovf_r    <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nx_s;
      rd_ptr_r <= rd_ptr_nx_s;
      count_r  <= count_nx_s;
      iready_r <= (count_nx_s < DEPTH_C);
      ovalid_r <= (count_nx_s != '0);
      odata_r  <= odata_nx_s;
      af_r     <= (count_nx_s >= AF_C);
      ae_r     <= (count_nx_s <= AE_C);
      ovf_r    <= ovf_nx_s;
    end
  end

  assign bus.iready       = iready_r;
  assign bus.ovalid       = ovalid_r;
  assign bus.odata        = odata_r;
  assign bus.count        = count_r;
  assign bus.almost_full  = af_r;
  assign bus.almost_empty = ae_r;
  assign bus.overflow     = ovf_r;
endmodule

// File: tb/tb_screen_fifo_param.sv
// Scoreboard bench for screen_fifo_param: directed stimulus queues expected
// words, an independent monitor checks every popped word and output hold.
module tb_screen_fifo_param;
  import screen_fifo_param_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  screen_word_t exp_q[$];

  screen_fifo_param_if #(.DW(10), .DEPTH(8)) bus ();

  screen_fifo_param #(.DW(10), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer n consecutive words, all expected to be accepted
  task automatic push_n(input int n, input screen_word_t base);
    for (int i = 0; i < n; i++) begin
      bus.ivalid = 1'b1;
      bus.idata  = screen_word_t'(base + screen_word_t'(i));
      exp_q.push_back(bus.idata);
      cyc();
    end
    bus.ivalid = 1'b0;
  endtask

  // Monitor: compare popped words with the scoreboard and check AXI-style hold
  initial begin
    logic         hold_pend;
    screen_word_t hold_data;
    hold_pend = 1'b0;
    hold_data = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (hold_pend) begin
          chk("hold_ovalid", 32'(bus.ovalid), 32'd1);
          chk("hold_odata", 32'(bus.odata), 32'(hold_data));
        end
        if (bus.ovalid && bus.oready && !bus.flush) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pop_unexpected: got 0x%0h, expected no word", bus.odata);
          end else begin
            chk("pop_data", 32'(bus.odata), 32'(exp_q.pop_front()));
          end
        end
        hold_pend = bus.ovalid && !bus.oready && !bus.flush;
        hold_data = bus.odata;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.flush   = 1'b0;
    bus.err_clr = 1'b0;
    bus.ivalid  = 1'b0;
    bus.idata   = '0;
    bus.oready  = 1'b0;

    // 1: reset values, then one idle cycle
    #12;
    chk("rst_iready", 32'(bus.iready), 32'd0);
    chk("rst_ae", 32'(bus.almost_empty), 32'd1);
    reset = 1'b0;
    cyc();
    chk("t1_iready", 32'(bus.iready), 32'd1);
    chk("t1_ovalid", 32'(bus.ovalid), 32'd0);
    chk("t1_count", 32'(bus.count), 32'd0);
    chk("t1_ae", 32'(bus.almost_empty), 32'd1);
    chk("t1_af", 32'(bus.almost_full), 32'd0);
    chk("t1_ovf", 32'(bus.overflow), 32'd0);

    // 2: single word falls through after one cycle and is held
    push_n(1, 10'h2A5);
    chk("t2_ovalid", 32'(bus.ovalid), 32'd1);
    chk("t2_odata", 32'(bus.odata), 32'h2A5);
    chk("t2_count", 32'(bus.count), 32'd1);
    for (int i = 0; i < 5; i++) cyc();
    bus.oready = 1'b1;
    cyc();
    bus.oready = 1'b0;
    chk("t2_empty_ovalid", 32'(bus.ovalid), 32'd0);
    chk("t2_empty_count", 32'(bus.count), 32'd0);

    // 3: fill to full, almost_full from 6, rejected 9th push, drain in order
    for (int i = 0; i < 8; i++) begin
      push_n(1, screen_word_t'(10'h201 + 10'(i)));
      chk("t3_count", 32'(bus.count), 32'(i + 1));
      chk("t3_af", 32'(bus.almost_full), (i + 1 >= 6) ? 32'd1 : 32'd0);
    end
    chk("t3_full_iready", 32'(bus.iready), 32'd0);
    bus.ivalid = 1'b1;
    bus.idata  = 10'h209;
    cyc();
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    chk("t3_ovf_count", 32'(bus.count), 32'd8);
    bus.idata  = 10'h2FF;
    bus.oready = 1'b1;
    cyc();
    bus.ivalid = 1'b0;
    chk("t3_fullpop_count", 32'(bus.count), 32'd7);
    chk("t3_fullpop_iready", 32'(bus.iready), 32'd1);
    for (int i = 0; i < 7; i++) cyc();
    bus.oready = 1'b0;
    chk("t3_drained_ovalid", 32'(bus.ovalid), 32'd0);
    chk("t3_drained_count", 32'(bus.count), 32'd0);

    // 4: steady streaming at count 4, pointers wrap
    push_n(4, 10'h300);
    bus.oready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.ivalid = 1'b1;
      bus.idata  = screen_word_t'(10'h304 + 10'(i));
      exp_q.push_back(bus.idata);
      cyc();
      chk("t4_count", 32'(bus.count), 32'd4);
    end
    bus.ivalid = 1'b0;
    for (int i = 0; i < 4; i++) cyc();
    bus.oready = 1'b0;
    chk("t4_drained_count", 32'(bus.count), 32'd0);

    // 5: flush discards contents and the word offered alongside it
    push_n(5, 10'h110);
    chk("t5_count", 32'(bus.count), 32'd5);
    bus.flush  = 1'b1;
    bus.ivalid = 1'b1;
    bus.idata  = 10'h1EE;
    exp_q.delete();
    cyc();
    bus.flush  = 1'b0;
    bus.ivalid = 1'b0;
    chk("t5_count0", 32'(bus.count), 32'd0);
    chk("t5_ovalid", 32'(bus.ovalid), 32'd0);
    chk("t5_iready", 32'(bus.iready), 32'd1);
    chk("t5_ae", 32'(bus.almost_empty), 32'd1);
    chk("t5_af", 32'(bus.almost_full), 32'd0);
    chk("t5_ovf_kept", 32'(bus.overflow), 32'd1);
    cyc();
    chk("t5_no_word", 32'(bus.ovalid), 32'd0);
    bus.err_clr = 1'b1;
    cyc();
    bus.err_clr = 1'b0;
    chk("t5_ovf_clr", 32'(bus.overflow), 32'd0);
    push_n(8, 10'h180);
    bus.ivalid  = 1'b1;
    bus.err_clr = 1'b1;
    cyc();
    bus.ivalid  = 1'b0;
    chk("t5_set_wins", 32'(bus.overflow), 32'd1);
    cyc();
    bus.err_clr = 1'b0;
    chk("t5_ovf_clr2", 32'(bus.overflow), 32'd0);
    bus.flush = 1'b1;
    exp_q.delete();
    cyc();
    bus.flush = 1'b0;
    chk("t5_flush2_count", 32'(bus.count), 32'd0);

    // 6: asynchronous reset in the middle of a drain
    push_n(5, 10'h150);
    bus.oready = 1'b1;
    cyc();
    cyc();
    chk("t6_count", 32'(bus.count), 32'd3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    exp_q.delete();
    #1;
    chk("t6_iready", 32'(bus.iready), 32'd0);
    chk("t6_ovalid", 32'(bus.ovalid), 32'd0);
    chk("t6_odata", 32'(bus.odata), 32'd0);
    chk("t6_count0", 32'(bus.count), 32'd0);
    chk("t6_ae", 32'(bus.almost_empty), 32'd1);
    chk("t6_af", 32'(bus.almost_full), 32'd0);
    bus.oready = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();
    chk("t6_iready_back", 32'(bus.iready), 32'd1);
    chk("t6_ovalid_back", 32'(bus.ovalid), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
